// File: rtl/ahb_slave_mem_if.sv
`default_nettype none
// =============================================================================
// Module   : ahb_slave_mem_if
// Brief    : AHB-Lite bus bundle between a master/decoder and ahb_slave_mem.
// Revision : 1.0
// =============================================================================
interface ahb_slave_mem_if;
   logic        hsel;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [1:0]  htrans;
   logic        hready;
   logic [31:0] hwdata;
   logic        hreadyout;
   logic        hresp;
   logic [31:0] hrdata;

   modport master (
      output hsel, haddr, hwrite, hsize, htrans, hready, hwdata,
      input  hreadyout, hresp, hrdata
   );

   modport slave (
      input  hsel, haddr, hwrite, hsize, htrans, hready, hwdata,
      output hreadyout, hresp, hrdata
   );
endinterface
`default_nettype wire

// File: rtl/ahb_slave_mem.sv
`default_nettype none
// =============================================================================
// Module   : ahb_slave_mem
// Brief    : AHB-Lite DEPTH x 32 register memory, programmable wait states,
//            two-cycle ERROR. Optional macro AHB_SLV_HTRANS_CHECK_EN.
// Revision : 1.0
// =============================================================================
module ahb_slave_mem #(
   parameter int DEPTH       = 16,
   parameter int WAIT_STATES = 1
) (
   input  logic           hclk_i,
   input  logic           hresetn_i,
   ahb_slave_mem_if.slave bus
);
   localparam int         AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] C_WS   = 4'(WAIT_STATES);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_WAIT = 3'd1;
   localparam logic [2:0] S_DATA = 3'd2;
   localparam logic [2:0] S_ERR1 = 3'd3;
   localparam logic [2:0] S_ERR2 = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [1:0]    lane_q, lane_d;
   logic [1:0]    size_q, size_d;
   logic          write_q, write_d;
   logic [31:0]   hrdata_q, hrdata_d;
   logic [31:0]   mem_q [DEPTH];

   logic          w_accept;
   logic          w_err;
   logic          w_commit;
   logic [3:0]    w_be;
   logic [31:0]   w_merged;
   logic [31:0]   w_rd_word;
   logic [AW-1:0] w_rd_idx;

`ifdef AHB_SLV_HTRANS_CHECK_EN
   assign w_accept = bus.hsel && bus.hready && bus.htrans[1];
`else
   assign w_accept = bus.hsel && bus.hready;
`endif

   assign w_err = (|bus.haddr[31:AW+2])
                || (bus.hsize > 3'd2)
                || ((bus.hsize == 3'd1) && bus.haddr[0])
                || ((bus.hsize == 3'd2) && (|bus.haddr[1:0]));

   assign w_commit = (state_q == S_DATA) && write_q;

   always_comb begin
      case (size_q)
         2'd0:    w_be = 4'b0001 << lane_q;
         2'd1:    w_be = lane_q[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      assign w_merged[8*i +: 8] = w_be[i] ? bus.hwdata[8*i +: 8] : mem_q[idx_q][8*i +: 8];
   end

   // A read loaded on the same edge a write commits must see the merged word.
   assign w_rd_idx  = (state_q == S_WAIT) ? idx_q : bus.haddr[AW+1:2];
   assign w_rd_word = (w_commit && (idx_q == w_rd_idx)) ? w_merged : mem_q[w_rd_idx];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lane_d   = lane_q;
      size_d   = size_q;
      write_d  = write_q;
      hrdata_d = hrdata_q;
      case (state_q)
         S_WAIT: begin
            if (cnt_q == C_WS) begin
               state_d = S_DATA;
               cnt_d   = 4'd0;
               if (!write_q) hrdata_d = w_rd_word;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_ERR1: state_d = S_ERR2;
         default: begin
            state_d = S_IDLE;
            if (w_accept) begin
               idx_d   = bus.haddr[AW+1:2];
               lane_d  = bus.haddr[1:0];
               size_d  = bus.hsize[1:0];
               write_d = bus.hwrite;
               if (w_err) begin
                  state_d = S_ERR1;
               end else if (C_WS != 4'd0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'd1;
               end else begin
                  state_d = S_DATA;
                  if (!bus.hwrite) hrdata_d = w_rd_word;
               end
            end
         end
      endcase
   end

   always_ff @(posedge hclk_i or negedge hresetn_i) begin
      if (!hresetn_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         lane_q   <= 2'd0;
         size_q   <= 2'd0;
         write_q  <= 1'b0;
         hrdata_q <= 32'd0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lane_q   <= lane_d;
         size_q   <= size_d;
         write_q  <= write_d;
         hrdata_q <= hrdata_d;
         if (w_commit) mem_q[idx_q] <= w_merged;
      end
   end

   assign bus.hreadyout = !((state_q == S_WAIT) || (state_q == S_ERR1));
   assign bus.hresp     = (state_q == S_ERR1) || (state_q == S_ERR2);
   assign bus.hrdata    = hrdata_q;
endmodule
`default_nettype wire
